motor_ramp_sched: RTL and testbench

- Slew-rate scheduler that sits directly upstream of the motor controller and drives its signed 11-bit lft/rht speed commands.
- Accepts target speeds through a valid/ready handshake.
- Ramps each channel toward its target in bounded steps on a prescaled tick.
- Forces a zero-speed (brake) dwell before any direction reversal, and supports an emergency stop.

---
 rtl/motor_ramp_sched.sv | 185 ++++++++++++++++++
 tb/tb_motor_ramp_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_ramp_sched.sv
`default_nettype none
// ============================================================================
//  Module      : motor_ramp_sched
//  Description : Slew-rate scheduler feeding the motor controller. Latches
//                a signed target pair through a valid/ready handshake and
//                ramps each channel toward its target by at most STEP per
//                prescaled tick. A direction reversal ramps to zero, holds
//                zero for DWELL_TICKS ticks, then ramps on. estop forces
//                everything to zero.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                tgt_lft/tgt_rht - signed 11-bit targets
//                tgt_vld/tgt_rdy - target handshake
//                estop           - synchronous emergency stop (level)
//                lft/rht         - signed 11-bit speed commands
//                busy            - some channel not settled at its target
//  Revision    : 1.0 - initial release
// ============================================================================
module motor_ramp_sched #(
    parameter int STEP        = 32,
    parameter int TICK_DIV    = 50000,
    parameter int DWELL_TICKS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [10:0] tgt_lft,
    input  logic signed [10:0] tgt_rht,
    input  logic               tgt_vld,
    output logic               tgt_rdy,
    input  logic               estop,
    output logic signed [10:0] lft,
    output logic signed [10:0] rht,
    output logic               busy
);

    localparam int c_pre_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_dcnt_w = (DWELL_TICKS > 0) ? $clog2(DWELL_TICKS + 1) : 1;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_ramp  = 2'd1;
    localparam logic [1:0] c_st_dwell = 2'd2;

    localparam logic signed [10:0] c_neg_full = 11'sh400;  // -1024
    localparam logic signed [10:0] c_neg_lim  = 11'sh401;  // -1023
    localparam logic [11:0]        c_step12   = 12'(STEP);
    localparam logic signed [10:0] c_step11   = 11'(STEP);

    logic [c_pre_w-1:0] r_pre;
    logic               w_tick;
    logic               w_accept;
    logic               r_rdy;
    logic               r_busy;
    logic [1:0][10:0]   w_cur;
    logic [1:0]         w_busy_nxt;

    assign w_tick   = (r_pre == c_pre_w'(TICK_DIV - 1));
    // Ready is the registered copy of ~estop, so acceptance follows what
    // the upstream side actually observes on tgt_rdy.
    assign w_accept = tgt_vld & r_rdy & ~estop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
        end else if (estop || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + c_pre_w'(1);
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic signed [10:0]  w_tgt_in;
        logic signed [10:0]  w_tgt_clamped;
        logic signed [10:0]  w_tgt_nxt;
        logic signed [10:0]  w_goal;
        logic signed [10:0]  w_stepped;
        logic signed [10:0]  w_cur_nxt;
        logic signed [11:0]  w_diff;
        logic [11:0]         w_mag;
        logic                w_rev;
        logic [1:0]          w_st_nxt;
        logic [c_dcnt_w-1:0] w_dcnt_nxt;
        logic [1:0]          r_st;
        logic signed [10:0]  r_cur;
        logic signed [10:0]  r_tgt;
        logic [c_dcnt_w-1:0] r_dcnt;

        assign w_tgt_in      = (g == 0) ? tgt_lft : tgt_rht;
        // -1024 has no positive mirror; clamping keeps the range symmetric.
        assign w_tgt_clamped = (w_tgt_in == c_neg_full) ? c_neg_lim : w_tgt_in;
        assign w_tgt_nxt     = w_accept ? w_tgt_clamped : r_tgt;

        // Opposite nonzero signs: head for zero first.
        assign w_rev  = (r_cur != '0) && (r_tgt != '0) && (r_cur[10] != r_tgt[10]);
        assign w_goal = w_rev ? '0 : r_tgt;
        // Sign-extended 12-bit difference: both operands lie within
        // [-1023, 1023], so the result never overflows.
        assign w_diff = {w_goal[10], w_goal} - {r_cur[10], r_cur};
        assign w_mag  = w_diff[11] ? 12'(-w_diff) : w_diff;

        always_comb begin
            if (w_mag <= c_step12) begin
                w_stepped = w_goal;
            end else if (w_diff[11]) begin
                w_stepped = r_cur - c_step11;
            end else begin
                w_stepped = r_cur + c_step11;
            end
        end

        always_comb begin
            w_st_nxt   = r_st;
            w_cur_nxt  = r_cur;
            w_dcnt_nxt = r_dcnt;
            if (w_tick) begin
                case (r_st)
                    c_st_idle: begin
                        if (r_tgt != r_cur) begin
                            w_st_nxt = c_st_ramp;
                        end
                    end
                    c_st_ramp: begin
                        w_cur_nxt = w_stepped;
                        if (w_rev && (w_stepped == '0)) begin
                            // Zero reached on the way through a reversal.
                            if (DWELL_TICKS > 0) begin
                                w_st_nxt   = c_st_dwell;
                                w_dcnt_nxt = c_dcnt_w'(DWELL_TICKS);
                            end
                        end else if (w_stepped == r_tgt) begin
                            w_st_nxt = c_st_idle;
                        end
                    end
                    c_st_dwell: begin
                        w_dcnt_nxt = r_dcnt - c_dcnt_w'(1);
                        if (r_dcnt == c_dcnt_w'(1)) begin
                            w_st_nxt = c_st_ramp;
                        end
                    end
                    default: begin
                        w_st_nxt = c_st_idle;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_st   <= c_st_idle;
                r_cur  <= '0;
                r_tgt  <= '0;
                r_dcnt <= '0;
            end else if (estop) begin
                r_st   <= c_st_idle;
                r_cur  <= '0;
                r_tgt  <= '0;
                r_dcnt <= '0;
            end else begin
                r_st   <= w_st_nxt;
                r_cur  <= w_cur_nxt;
                r_tgt  <= w_tgt_nxt;
                r_dcnt <= w_dcnt_nxt;
            end
        end

        assign w_cur[g]      = r_cur;
        assign w_busy_nxt[g] = (w_st_nxt != c_st_idle) || (w_cur_nxt != w_tgt_nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy  <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            r_rdy  <= ~estop;
            r_busy <= ~estop & (|w_busy_nxt);
        end
    end

    assign tgt_rdy = r_rdy;
    assign busy    = r_busy;
    assign lft     = w_cur[0];
    assign rht     = w_cur[1];

endmodule
`default_nettype wire

// File: tb/tb_motor_ramp_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_motor_ramp_sched
//  Description : Directed table-driven bench for motor_ramp_sched with
//                hand-written sequences for estop, reset and clamping.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_ramp_sched;

    typedef struct {
        bit vld;
        bit late;
        int tl;
        int tr;
        int el;
        int er;
        int eb;
    } vec_t;

    logic               clk;
    logic               rst;
    logic signed [10:0] tgt_lft;
    logic signed [10:0] tgt_rht;
    logic               tgt_vld;
    logic               tgt_rdy;
    logic               estop;
    logic signed [10:0] lft;
    logic signed [10:0] rht;
    logic               busy;

    logic signed [10:0] u1_tgt_lft;
    logic signed [10:0] u1_tgt_rht;
    logic               u1_vld;
    logic               u1_rdy;
    logic               u1_estop;
    logic signed [10:0] u1_lft;
    logic signed [10:0] u1_rht;
    logic               u1_busy;

    int   n_vec;
    int   n_bad;
    int   ph;
    bit   was_tick;
    int   hold_l;
    int   hold_r;
    vec_t tbl[$];

    motor_ramp_sched #(.STEP(32), .TICK_DIV(4), .DWELL_TICKS(3)) u_dut (
        .clk(clk), .rst(rst), .tgt_lft(tgt_lft), .tgt_rht(tgt_rht),
        .tgt_vld(tgt_vld), .tgt_rdy(tgt_rdy), .estop(estop),
        .lft(lft), .rht(rht), .busy(busy)
    );

    motor_ramp_sched #(.STEP(1023), .TICK_DIV(4), .DWELL_TICKS(0)) u_dut_x (
        .clk(clk), .rst(rst), .tgt_lft(u1_tgt_lft), .tgt_rht(u1_tgt_rht),
        .tgt_vld(u1_vld), .tgt_rdy(u1_rdy), .estop(u1_estop),
        .lft(u1_lft), .rht(u1_rht), .busy(u1_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic add(input int vld, input int late, input int tl, input int tr,
                       input int el, input int er, input int eb);
        vec_t v;
        v.vld  = (vld != 0);
        v.late = (late != 0);
        v.tl   = tl;
        v.tr   = tr;
        v.el   = el;
        v.er   = er;
        v.eb   = eb;
        tbl.push_back(v);
    endtask

    // One clock edge; ph models the prescaler so the bench knows tick edges.
    task automatic step();
        was_tick = (ph == 3) && !estop;
        @(posedge clk);
        #1;
        if (estop) ph = 0;
        else       ph = (ph == 3) ? 0 : ph + 1;
    endtask

    // Runs up to and including the next tick edge. Non-late rows present the
    // target on the first edge; late rows present it on the tick edge itself.
    task automatic apply(input int idx);
        vec_t v;
        bit   done;
        v    = tbl[idx];
        done = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            if (v.vld && ((!v.late && k == 0) || (v.late && ph == 3))) begin
                tgt_vld = 1'b1;
                tgt_lft = 11'(v.tl);
                tgt_rht = 11'(v.tr);
            end
            step();
            tgt_vld = 1'b0;
            if (was_tick) begin
                done = 1'b1;
                chk($sformatf("v%0d lft", idx), int'(lft), v.el);
                chk($sformatf("v%0d rht", idx), int'(rht), v.er);
                chk($sformatf("v%0d busy", idx), int'(busy), v.eb);
                hold_l = v.el;
                hold_r = v.er;
            end else begin
                chk($sformatf("v%0d hold lft", idx), int'(lft), hold_l);
                chk($sformatf("v%0d hold rht", idx), int'(rht), hold_r);
            end
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL v%0d tick: got none, expected a tick within 8 edges", idx);
        end
    endtask

    task automatic apply_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) apply(i);
    endtask

    task automatic tick1(input bit vld, input int tl, input int tr,
                         input int el, input int er, input int eb, input string nm);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            if (vld && k == 0) begin
                u1_vld     = 1'b1;
                u1_tgt_lft = 11'(tl);
                u1_tgt_rht = 11'(tr);
            end
            step();
            u1_vld = 1'b0;
            if (was_tick) begin
                done = 1'b1;
                chk({nm, " lft"}, int'(u1_lft), el);
                chk({nm, " rht"}, int'(u1_rht), er);
                chk({nm, " busy"}, int'(u1_busy), eb);
            end
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s tick: got none, expected a tick within 8 edges", nm);
        end
    endtask

    initial begin
        n_vec = 0;  n_bad = 0;  ph = 0;  was_tick = 1'b0;
        hold_l = 0; hold_r = 0;
        rst = 1'b1; estop = 1'b0; tgt_vld = 1'b0; tgt_lft = '0; tgt_rht = '0;
        u1_vld = 1'b0; u1_estop = 1'b0; u1_tgt_lft = '0; u1_tgt_rht = '0;

        // ramp up from rest (0..4)
        add(1,0, 100, 40,    0,  0, 1);
        add(0,0,   0,  0,   32, 32, 1);
        add(0,0,   0,  0,   64, 40, 1);
        add(0,0,   0,  0,   96, 40, 1);
        add(0,0,   0,  0,  100, 40, 0);
        // reversal with dwell; new target during dwell (5..15)
        add(1,0, -50, 40,  100, 40, 1);
        add(0,0,   0,  0,   68, 40, 1);
        add(0,0,   0,  0,   36, 40, 1);
        add(0,0,   0,  0,    4, 40, 1);
        add(0,0,   0,  0,    0, 40, 1);
        add(1,0, -80, 40,    0, 40, 1);
        add(0,0,   0,  0,    0, 40, 1);
        add(0,0,   0,  0,    0, 40, 1);
        add(0,0,   0,  0,  -32, 40, 1);
        add(0,0,   0,  0,  -64, 40, 1);
        add(0,0,   0,  0,  -80, 40, 0);
        // accept coinciding with a tick (16..22)
        add(1,0, -16, 40,  -80, 40, 1);
        add(0,0,   0,  0,  -48, 40, 1);
        add(1,1,-100, 40,  -16, 40, 1);
        add(0,0,   0,  0,  -16, 40, 1);
        add(0,0,   0,  0,  -48, 40, 1);
        add(0,0,   0,  0,  -80, 40, 1);
        add(0,0,   0,  0, -100, 40, 0);
        // mid-ramp before estop (23..24)
        add(1,0,-200, 40, -100, 40, 1);
        add(0,0,   0,  0, -132, 40, 1);
        // after estop release (25..26)
        add(1,0,  20,  0,    0,  0, 1);
        add(0,0,   0,  0,   20,  0, 0);
        // into dwell before async reset (27..29)
        add(1,0, -10,100,   20,  0, 1);
        add(0,0,   0,  0,    0, 32, 1);
        add(0,0,   0,  0,    0, 64, 1);
        // after reset: stays idle (30..31)
        add(0,0,   0,  0,    0,  0, 0);
        add(0,0,   0,  0,    0,  0, 0);

        #12;
        chk("reset lft", int'(lft), 0);
        chk("reset rht", int'(rht), 0);
        chk("reset busy", int'(busy), 0);
        #10;
        rst = 1'b0;
        #1;
        chk("reset rdy", int'(tgt_rdy), 1);
        ph = 0;

        // clamp and full-scale reversal, STEP=1023, no dwell
        tick1(1'b1,  1023,     0,     0,     0, 1, "clamp c1");
        tick1(1'b0,     0,     0,  1023,     0, 0, "clamp c2");
        tick1(1'b1, -1024, -1024,  1023,     0, 1, "clamp c3");
        tick1(1'b0,     0,     0,     0, -1023, 1, "clamp c4");
        tick1(1'b0,     0,     0, -1023, -1023, 0, "clamp c5");

        apply_range(0, 24);

        // emergency stop mid-ramp, with tgt_vld asserted throughout
        estop = 1'b1; tgt_vld = 1'b1; tgt_lft = 11'sd500; tgt_rht = -11'sd500;
        step();
        chk("estop lft", int'(lft), 0);
        chk("estop rht", int'(rht), 0);
        chk("estop busy", int'(busy), 0);
        chk("estop rdy", int'(tgt_rdy), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("estop hold lft", int'(lft), 0);
            chk("estop hold rht", int'(rht), 0);
        end
        estop = 1'b0; tgt_vld = 1'b0;
        step();
        chk("release rdy", int'(tgt_rdy), 1);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("released lft", int'(lft), 0);
            chk("released rht", int'(rht), 0);
            chk("released busy", int'(busy), 0);
        end
        hold_l = 0; hold_r = 0;
        apply_range(25, 29);

        // asynchronous reset while lft dwells and rht ramps
        #3;
        rst = 1'b1;
        #1;
        chk("async rst lft", int'(lft), 0);
        chk("async rst rht", int'(rht), 0);
        chk("async rst busy", int'(busy), 0);
        chk("async rst x lft", int'(u1_lft), 0);
        #2;
        rst = 1'b0;
        ph = 0; hold_l = 0; hold_r = 0;
        #1;
        chk("post rst rdy", int'(tgt_rdy), 1);
        apply_range(30, 31);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
